// File: rtl/ssp_uart_pkg.sv
// Shared types and constants for the ssp_uart host controller.
// Covers register addresses, host FSM states and register reset values.
package ssp_uart_pkg;

  localparam int SSP_DW = 12;

  typedef enum logic [2:0] {
    UCR = 3'b000,
    USR = 3'b001,
    TDR = 3'b010,
    RDR = 3'b011,
    SPR = 3'b100
  } ssp_reg_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_EOC    = 3'd4,
    ST_DONE   = 3'd5
  } host_state_e;

  localparam logic [11:0] UCR_RST = 12'h000;
  localparam logic [11:0] USR_RST = 12'h000;
  localparam logic [11:0] TDR_RST = 12'h000;
  localparam logic [11:0] RDR_RST = 12'h000;
  localparam logic [11:0] SPR_RST = 12'h000;

  function automatic logic ra_valid(input logic [2:0] ra);
    return (ra <= 3'b100);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer always moves to the port that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       win_idx
);

  logic ptr_q;
  logic ptr_d;

  // Pick the winner and compute the next pointer.
  always_comb begin
    win_idx = 1'b0;
    ptr_d   = ptr_q;
    if (req == 2'b11) begin
      win_idx = ptr_q;
    end else if (req[1]) begin
      win_idx = 1'b1;
    end else begin
      win_idx = 1'b0;
    end
    if (gnt_en && (req != 2'b00)) begin
      ptr_d = ~win_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ssp_uart_host_ctrl.sv
// SSP bus master sequencing register cycles into ssp_uart for two arbitrated requesters.
// All bus and handshake outputs are registered copies of the next-state decode.
module ssp_uart_host_ctrl
  import ssp_uart_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 2,
  parameter int DW        = SSP_DW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [1:0]    Req,
  input  logic [2:0]    ReqRA_0,
  input  logic [2:0]    ReqRA_1,
  input  logic          ReqWnR_0,
  input  logic          ReqWnR_1,
  input  logic [DW-1:0] ReqDI_0,
  input  logic [DW-1:0] ReqDI_1,
  output logic [1:0]    Gnt,
  output logic [1:0]    Done,
  output logic [1:0]    Err,
  output logic [DW-1:0] RdData,
  output logic          SSP_SSEL,
  output logic [2:0]    SSP_RA,
  output logic          SSP_WnR,
  output logic          SSP_En,
  output logic          SSP_EOC,
  output logic [DW-1:0] SSP_DI,
  input  logic [DW-1:0] SSP_DO
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end
  if (DW != 12) begin : g_bad_dw
    $error("DW is fixed to 12 for ssp_uart");
  end

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  host_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [2:0]    ra_q, ra_d;
  logic          wnr_q, wnr_d;
  logic [DW-1:0] di_q, di_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          ssel_q, ssel_d;
  logic          en_q, en_d;
  logic          eoc_q, eoc_d;
  logic          arb_en;
  logic          win_idx;
  logic [2:0]    win_ra;
  logic          win_wnr;
  logic [DW-1:0] win_di;
  logic [1:0]    owner_oh;

  rr_arb2 u_arb (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .req     (Req),
    .gnt_en  (arb_en),
    .win_idx (win_idx)
  );

  // Route the winning requester's command fields.
  always_comb begin
    win_ra  = win_idx ? ReqRA_1  : ReqRA_0;
    win_wnr = win_idx ? ReqWnR_1 : ReqWnR_0;
    win_di  = win_idx ? ReqDI_1  : ReqDI_0;
  end

  // Next-state, counter, command capture and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ra_d    = ra_q;
    wnr_d   = wnr_q;
    di_d    = di_q;
    rd_d    = rd_q;
    err_d   = 2'b00;
    arb_en  = 1'b0;
    case (state_q)
      // An Err pulse still visible means its Req has not been dropped yet.
      ST_IDLE: begin
        if ((Req != 2'b00) && (err_q == 2'b00)) begin
          arb_en = 1'b1;
          if (ra_valid(win_ra)) begin
            owner_d = win_idx;
            ra_d    = win_ra;
            wnr_d   = win_wnr;
            di_d    = win_di;
            cnt_d   = SETUP_LD;
            state_d = ST_SETUP;
          end else begin
            err_d = win_idx ? 2'b10 : 2'b01;
          end
        end else begin
          arb_en = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        cnt_d   = HOLD_LD;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_EOC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_EOC: begin
        if (!wnr_q) begin
          rd_d = SSP_DO;
        end else begin
          rd_d = rd_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    owner_oh = owner_d ? 2'b10 : 2'b01;
    ssel_d   = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_EOC};
    en_d     = (state_d == ST_STROBE);
    eoc_d    = (state_d == ST_EOC);
    gnt_d    = ssel_d ? owner_oh : 2'b00;
    done_d   = (state_d == ST_DONE) ? owner_oh : 2'b00;
  end

  // State, counter and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      ra_q    <= 3'b000;
      wnr_q   <= 1'b0;
      di_q    <= '0;
      rd_q    <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      ssel_q  <= 1'b0;
      en_q    <= 1'b0;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ra_q    <= ra_d;
      wnr_q   <= wnr_d;
      di_q    <= di_d;
      rd_q    <= rd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ssel_q  <= ssel_d;
      en_q    <= en_d;
      eoc_q   <= eoc_d;
    end
  end

  assign Gnt      = gnt_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign RdData   = rd_q;
  assign SSP_SSEL = ssel_q;
  assign SSP_RA   = ra_q;
  assign SSP_WnR  = wnr_q;
  assign SSP_En   = en_q;
  assign SSP_EOC  = eoc_q;
  assign SSP_DI   = di_q;

endmodule

// File: tb/tb_ssp_uart_host_ctrl.sv
// Scoreboard bench for ssp_uart_host_ctrl with a small ssp_uart register model as bus slave.
module tb_ssp_uart_host_ctrl;
  import ssp_uart_pkg::*;

  localparam int SETUP_CYC = 1;
  localparam int HOLD_CYC  = 2;

  typedef struct {
    logic        is_err;
    logic        chk_rd;
    logic [11:0] data;
    int          issue;
    logic        chk_lat;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  Req;
  logic [2:0]  ReqRA_0, ReqRA_1;
  logic        ReqWnR_0, ReqWnR_1;
  logic [11:0] ReqDI_0, ReqDI_1;
  logic [1:0]  Gnt, Done, Err;
  logic [11:0] RdData;
  logic        SSP_SSEL, SSP_WnR, SSP_En, SSP_EOC;
  logic [2:0]  SSP_RA;
  logic [11:0] SSP_DI, SSP_DO;

  logic [11:0] regs [0:7];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic gap_mode = 1'b0;
  logic quiet_mode = 1'b0;
  logic bus_act = 1'b0;
  logic [3:0] gnt_order = 4'b0000;
  int   n_gnt = 0;

  ssp_uart_host_ctrl #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .DW(12)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req),
    .ReqRA_0(ReqRA_0), .ReqRA_1(ReqRA_1), .ReqWnR_0(ReqWnR_0), .ReqWnR_1(ReqWnR_1),
    .ReqDI_0(ReqDI_0), .ReqDI_1(ReqDI_1),
    .Gnt(Gnt), .Done(Done), .Err(Err), .RdData(RdData),
    .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_En(SSP_En),
    .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // ssp_uart register model: writes land on SSP_En, reads are combinational.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= 12'h000;
      regs[USR] <= 12'h3C1;
    end else if (SSP_En && SSP_WnR) begin
      regs[SSP_RA] <= SSP_DI;
    end
  end
  assign SSP_DO = (SSP_SSEL && !SSP_WnR) ? regs[SSP_RA] : 12'h000;

  function automatic logic [63:0] outs();
    return 64'({Gnt, Done, Err, RdData, SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic gnt_prev, ssel_prev, have_fall, got;
    int   gnt_rise, en_c, fall_c;
    exp_t e;
    gnt_prev = 1'b0; ssel_prev = 1'b0; have_fall = 1'b0;
    gnt_rise = 0; en_c = 0; fall_c = 0;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        for (int p = 0; p < 2; p++) begin
          if (Done[p] || Err[p]) begin
            got = 1'b0;
            if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            else if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
              total++; bad++;
              $display("FAIL unexpected_resp: port %0d got Done=%b Err=%b, want none", p, Done[p], Err[p]);
            end else begin
              chk($sformatf("resp_kind_p%0d", p), 64'({Done[p], Err[p]}), e.is_err ? 64'd1 : 64'd2);
              if (e.chk_rd) chk($sformatf("rd_data_p%0d", p), 64'(RdData), 64'(e.data));
              if (e.chk_lat) begin
                if (e.is_err) chk("err_latency", 64'(cyc - e.issue), 64'd1);
                else chk("done_latency", 64'(cyc - e.issue + 1), 64'(SETUP_CYC + HOLD_CYC + 4));
              end
            end
          end
        end
        if (Gnt != 2'b00) chk("gnt_onehot", 64'($onehot(Gnt)), 64'd1);
        if ((Gnt != 2'b00) && !gnt_prev) begin
          gnt_rise = cyc;
          if (gap_mode) begin
            if (n_gnt < 4) gnt_order[n_gnt] = Gnt[1];
            n_gnt++;
          end
        end
        if (SSP_En) begin
          chk("en_after_gnt", 64'(cyc - gnt_rise), 64'(SETUP_CYC));
          en_c = cyc;
        end
        if (SSP_EOC) chk("eoc_after_en", 64'(cyc - en_c), 64'(HOLD_CYC + 1));
        if (SSP_SSEL && !ssel_prev && have_fall && gap_mode)
          chk("ssel_gap", 64'((cyc - fall_c) <= 2), 64'd1);
        if (!SSP_SSEL && ssel_prev && gap_mode) begin
          fall_c = cyc;
          have_fall = 1'b1;
        end
        if (!gap_mode) have_fall = 1'b0;
        if (quiet_mode) bus_act = bus_act | SSP_SSEL | SSP_En | SSP_EOC | (|Gnt) | (|Done);
        gnt_prev  = (Gnt != 2'b00);
        ssel_prev = SSP_SSEL;
      end else begin
        gnt_prev = 1'b0; ssel_prev = 1'b0; have_fall = 1'b0;
      end
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] ra, input logic wnr, input logic [11:0] di);
    if (p == 0) begin ReqRA_0 = ra; ReqWnR_0 = wnr; ReqDI_0 = di; end
    else begin ReqRA_1 = ra; ReqWnR_1 = wnr; ReqDI_1 = di; end
  endtask

  // Single request from an idle controller; command inputs are scrambled once granted.
  task automatic do_req(input int p, input logic [2:0] ra, input logic wnr, input logic [11:0] di,
                        input logic is_err, input logic chk_rd, input logic [11:0] rd);
    exp_t e;
    int   n;
    e.is_err = is_err; e.chk_rd = chk_rd; e.data = rd; e.issue = cyc; e.chk_lat = 1'b1;
    set_port(p, ra, wnr, di);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    Req[p] = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) set_port(p, ra ^ 3'b001, ~wnr, ~di);
    end while (!(Done[p] || Err[p]) && n < 40);
    if (!(Done[p] || Err[p])) begin
      total++; bad++;
      $display("FAIL timeout_p%0d: no response after %0d cycles, want one", p, n);
    end
    Req[p] = 1'b0;
    @(negedge Clk);
  endtask

  // Requester that keeps Req high across back-to-back TDR writes.
  task automatic pump(input int p, input int n_tx);
    exp_t e;
    int   n;
    for (int k = 0; k < n_tx; k++) begin
      e.is_err = 1'b0; e.chk_rd = 1'b0; e.data = 12'h000; e.issue = cyc; e.chk_lat = 1'b0;
      set_port(p, TDR, 1'b1, 12'h200 + 12'(p * 16 + k));
      if (p == 0) q0.push_back(e); else q1.push_back(e);
      Req[p] = 1'b1;
      n = 0;
      do begin
        @(negedge Clk);
        n++;
      end while (!Done[p] && n < 60);
      if (!Done[p]) begin
        total++; bad++;
        $display("FAIL pump_timeout_p%0d: no Done after %0d cycles, want one", p, n);
      end
    end
    Req[p] = 1'b0;
  endtask

  initial begin
    int n;
    Rst_n = 1'b0; Req = 2'b00;
    set_port(0, 3'b000, 1'b0, 12'h000);
    set_port(1, 3'b000, 1'b0, 12'h000);
    repeat (10) @(negedge Clk);
    chk("reset_outputs", outs(), 64'd0);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_after_reset", outs(), 64'd0);
    fork monitor(); join_none

    do_req(0, UCR, 1'b1, 12'hA5C, 1'b0, 1'b0, 12'h000);
    chk("ucr_written", 64'(regs[UCR]), 64'h A5C);
    do_req(0, UCR, 1'b0, 12'h000, 1'b0, 1'b1, 12'hA5C);
    do_req(1, USR, 1'b0, 12'h000, 1'b0, 1'b1, 12'h3C1);

    n_gnt = 0; gnt_order = 4'b0000; gap_mode = 1'b1;
    fork
      pump(0, 2);
      pump(1, 2);
    join
    @(negedge Clk);
    gap_mode = 1'b0;
    chk("grant_count", 64'(n_gnt), 64'd4);
    chk("grant_order", 64'(gnt_order), 64'b1010);
    chk("tdr_last", 64'(regs[TDR]), 64'h211);

    bus_act = 1'b0; quiet_mode = 1'b1;
    do_req(0, 3'b110, 1'b1, 12'hFFF, 1'b1, 1'b0, 12'h000);
    quiet_mode = 1'b0;
    chk("bad_addr_quiet", 64'(bus_act), 64'd0);
    do_req(1, USR, 1'b0, 12'h000, 1'b0, 1'b1, 12'h3C1);

    set_port(0, TDR, 1'b1, 12'h777);
    Req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!SSP_En && n < 20);
    chk("en_seen", 64'(SSP_En), 64'd1);
    @(posedge Clk);
    #1 chk("pre_rst_hold", 64'({SSP_SSEL, Gnt}), 64'b101);
    #1 Rst_n = 1'b0;
    #1 chk("rst_clears", outs(), 64'd0);
    Req = 2'b00;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    do_req(0, SPR, 1'b1, 12'h055, 1'b0, 1'b0, 12'h000);
    do_req(0, SPR, 1'b0, 12'h000, 1'b0, 1'b1, 12'h055);

    repeat (3) @(negedge Clk);
    chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
